// File: rtl/onehot_operand_encoder.sv
// Builds a legal one-hot operand set A1..A4 from an (index, value) request.
// Each request sweeps all four slots, one per cycle, then holds the set until it is consumed.
module onehot_operand_encoder #(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned CLR_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_idx,
  input  logic [WIDTH-1:0] in_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A1,
  output logic [WIDTH-1:0] A2,
  output logic [WIDTH-1:0] A3,
  output logic [WIDTH-1:0] A4,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StValid
  } state_e;

  localparam logic [1:0] LastCnt = 2'(CLR_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] slot_q [4];
  logic [WIDTH-1:0] slot_d [4];
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    val_d   = val_q;
    err_d   = err_q;
    for (int i = 0; i < 4; i++) begin
      slot_d[i] = slot_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          state_d = StSweep;
          idx_d   = in_idx;
          val_d   = in_val;
          cnt_d   = 2'd0;
          if (in_val == '0) begin
            err_d = 1'b1;
          end
        end
      end
      StSweep: begin
        // Every slot is rewritten so a stale value from the previous set can never survive.
        slot_d[cnt_q] = (cnt_q == idx_q) ? val_q : '0;
        cnt_d         = cnt_q + 2'd1;
        if (cnt_q == LastCnt) begin
          state_d = StValid;
        end
      end
      StValid: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StValid);
    busy_d      = (state_d == StSweep);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      idx_q       <= 2'd0;
      val_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      val_q       <= val_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign A1        = slot_q[0];
  assign A2        = slot_q[1];
  assign A3        = slot_q[2];
  assign A4        = slot_q[3];

endmodule
